// File: rtl/muu_collapser_pkg.sv
// Shared definitions for the data collapser: FSM states, counter width and
// the error-count saturation value.
package muu_collapser_pkg;

    localparam int COUNT_W = 8;
    localparam logic [COUNT_W-1:0] ERR_SAT = 8'd255;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        CHECK,
        STATUS
    } state_t;

    // Increment that sticks at the saturation value instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == ERR_SAT) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/muu_collapser_outreg.sv
// Single-entry valid/ready register feeding the collapsed output stream.
// It accepts a new word whenever it is empty or its content is leaving
// on the same cycle, so a full-rate stream passes without bubbles.
module muu_collapser_outreg
    import muu_collapser_pkg::*;
#(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    assign in_ready = !out_valid || out_ready;

    // Occupancy flag: set on a load, cleared when the word is taken and nothing replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Data capture; no reset needed because out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/muu_data_collapser.sv
// Collapses a stream made of `count` back-to-back copies of a `size`-word
// block into one copy of the block, and reports how many words of the
// later copies differed from the first one.
// Build option: define MUU_COLLAPSER_CHECK_EN to store the first copy and
// compare the repeats against it; without it the repeats are simply
// drained and the reported error count is always zero.
module muu_data_collapser
    import muu_collapser_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int DATA_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,

    input  logic [COUNT_W-1:0]    config_count,
    input  logic [COUNT_W-1:0]    config_size,
    input  logic                  config_valid,
    output logic                  config_ready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,

    output logic [COUNT_W-1:0]    status_errcount,
    output logic                  status_valid,
    input  logic                  status_ready
);

    state_t             state;
    logic [COUNT_W-1:0] job_count;
    logic [COUNT_W-1:0] job_size;
    logic [COUNT_W-1:0] word_idx;
    logic [COUNT_W-1:0] rep_idx;
    logic [COUNT_W-1:0] errcount;

    logic fwd_ready;
    logic s_fire;
    logic last_word;
    logic last_rep;

    assign config_ready    = (state == IDLE) && !rst;
    assign s_axis_tready   = (state == FIRST) ? fwd_ready : (state == CHECK);
    assign status_valid    = (state == STATUS) && !m_axis_tvalid;
    assign status_errcount = errcount;

    assign s_fire    = s_axis_tvalid && s_axis_tready;
    assign last_word = (word_idx == job_size - 8'd1);
    assign last_rep  = (rep_idx == job_count - 8'd1);

    muu_collapser_outreg #(
        .WIDTH(DATA_WIDTH)
    ) u_outreg (
        .clk      (clk),
        .rst      (rst),
        .in_data  (s_axis_tdata),
        .in_valid ((state == FIRST) && s_axis_tvalid),
        .in_ready (fwd_ready),
        .out_data (m_axis_tdata),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );

`ifdef MUU_COLLAPSER_CHECK_EN
    localparam int ADDR_W = $clog2(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] ref_store [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] ref_word;

    assign ref_word = ref_store[ADDR_W'(word_idx)];

    // Keep the first copy of the block so later copies can be compared word by word.
    always_ff @(posedge clk) begin
        if ((state == FIRST) && s_fire) begin
            ref_store[ADDR_W'(word_idx)] <= s_axis_tdata;
        end
    end
`endif

    // Job sequencing: latch the job, pass the first copy through, check the repeats, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            job_count <= '0;
            job_size  <= '0;
            word_idx  <= '0;
            rep_idx   <= '0;
            errcount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (config_valid && config_ready) begin
                        job_count <= config_count;
                        job_size  <= config_size;
                        word_idx  <= '0;
                        rep_idx   <= '0;
                        errcount  <= '0;
                        state     <= (config_count == 8'd0 || config_size == 8'd0) ? STATUS : FIRST;
                    end
                end
                FIRST: begin
                    if (s_fire) begin
                        if (last_word) begin
                            word_idx <= '0;
                            rep_idx  <= 8'd1;
                            state    <= (job_count > 8'd1) ? CHECK : STATUS;
                        end else begin
                            word_idx <= word_idx + 8'd1;
                        end
                    end
                end
                CHECK: begin
                    if (s_fire) begin
`ifdef MUU_COLLAPSER_CHECK_EN
                        if (s_axis_tdata != ref_word) begin
                            errcount <= sat_inc(errcount);
                        end
`endif
                        if (last_word) begin
                            word_idx <= '0;
                            if (last_rep) begin
                                state <= STATUS;
                            end else begin
                                rep_idx <= rep_idx + 8'd1;
                            end
                        end else begin
                            word_idx <= word_idx + 8'd1;
                        end
                    end
                end
                STATUS: begin
                    if (status_valid && status_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muu_data_collapser.sv
// Randomized self-checking bench for muu_data_collapser. Each job's expected
// output block, consumed word count and error count are computed directly
// from the job's stimulus list before the job is played into the design.
`timescale 1ns/1ps
module tb_muu_data_collapser;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [7:0]    config_count;
    logic [7:0]    config_size;
    logic          config_valid;
    logic          config_ready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [7:0]    status_errcount;
    logic          status_valid;
    logic          status_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] stim [$];
    logic [DW-1:0] out_q [$];
    int s_accepts       = 0;
    int stall_left      = 0;
    int snap_accepts    = -1;
    int ready_pct       = 100;
    int valid_pct       = 100;
    int status_pct      = 100;
    bit status_early    = 1'b0;

    always #5 clk = ~clk;

    muu_data_collapser #(
        .DATA_WIDTH(DW),
        .DATA_DEPTH(256)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .config_count   (config_count),
        .config_size    (config_size),
        .config_valid   (config_valid),
        .config_ready   (config_ready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .status_errcount(status_errcount),
        .status_valid   (status_valid),
        .status_ready   (status_ready)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Handshake monitor, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) out_q.push_back(m_axis_tdata);
            if (s_axis_tvalid && s_axis_tready) s_accepts++;
            if (status_valid && m_axis_tvalid) status_early = 1'b1;
        end
    end

    // Downstream ready generators, with an optional forced stall on m_axis.
    initial begin
        m_axis_tready = 1'b0;
        status_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                m_axis_tready = 1'b0;
                stall_left--;
                if (stall_left == 0) snap_accepts = s_accepts;
            end else begin
                m_axis_tready = ($urandom_range(99) < ready_pct);
            end
            status_ready = ($urandom_range(99) < status_pct);
        end
    end

    // Plays one job from stim[]; abort_after > 0 stops feeding after that many words.
    task automatic applyStimulus(input int cnt, input int sz, input int abort_after, input string name);
        int total;
        int idx;
        int cycles;
        int exp_err;
        int nout;
        bit done;
        logic [7:0] got_err;
        logic [DW-1:0] exp_out [$];

        total   = (cnt == 0 || sz == 0) ? 0 : cnt * sz;
        exp_err = 0;
        nout    = 0;
        got_err = '0;
        if (total > 0) begin
            for (int i = 0; i < sz; i++) exp_out.push_back(stim[i]);
            for (int i = sz; i < total; i++) if (stim[i] !== stim[i % sz]) exp_err++;
        end
        if (exp_err > 255) exp_err = 255;
`ifndef MUU_COLLAPSER_CHECK_EN
        exp_err = 0;
`endif

        @(posedge clk);
        #1;
        out_q.delete();
        s_accepts    = 0;
        status_early = 1'b0;
        config_count = cnt[7:0];
        config_size  = sz[7:0];
        config_valid = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (config_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        config_valid = 1'b0;
        checkOutput({name, " cfg_accept"}, done, 1);
        if (!done) return;

        idx = 0;
        cycles = 0;
        while (idx < total && cycles < 5000) begin
            if (abort_after > 0 && idx == abort_after) break;
            s_axis_tvalid = ($urandom_range(99) < valid_pct);
            s_axis_tdata  = stim[idx];
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) idx++;
            @(posedge clk);
            #1;
            cycles++;
        end
        s_axis_tvalid = 1'b0;
        if (abort_after > 0) return;
        checkOutput({name, " words_fed"}, idx, total);

        s_axis_tvalid = (total == 0);
        s_axis_tdata  = {$urandom, $urandom};
        done = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            if (c == 0 && total == 0) checkOutput({name, " status_next_cycle"}, status_valid, 1);
            if (status_valid && status_ready) begin
                done    = 1'b1;
                got_err = status_errcount;
                nout    = out_q.size();
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;

        checkOutput({name, " status_seen"}, done, 1);
        if (!done) return;
        checkOutput({name, " out_count"}, nout, exp_out.size());
        for (int i = 0; i < nout && i < exp_out.size(); i++) begin
            checkOutput({name, " out_word"}, out_q[i], exp_out[i]);
        end
        checkOutput({name, " consumed"}, s_accepts, total);
        checkOutput({name, " errcount"}, got_err, exp_err);
        checkOutput({name, " status_order"}, status_early, 0);
    endtask

    // Safety net against a design that never completes a handshake.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: time limit reached, observed no summary expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] w;
        int cnt;
        int sz;
        int total;

        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        config_count  = '0;
        config_size   = '0;
        config_valid  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset config_ready", config_ready, 0);
        checkOutput("reset s_axis_tready", s_axis_tready, 0);
        checkOutput("reset m_axis_tvalid", m_axis_tvalid, 0);
        checkOutput("reset status_valid", status_valid, 0);
        checkOutput("reset errcount", status_errcount, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("config_ready after reset", config_ready, 1);

        // Three clean copies of A,B,C,D.
        ready_pct = 70; valid_pct = 80; status_pct = 50;
        stim.delete();
        for (int r = 0; r < 3; r++) begin
            stim.push_back(64'hA); stim.push_back(64'hB);
            stim.push_back(64'hC); stim.push_back(64'hD);
        end
        applyStimulus(3, 4, 0, "abcd_x3");

        // One mismatch in the second copy.
        stim.delete();
        stim.push_back(64'd1); stim.push_back(64'd2);
        stim.push_back(64'd1); stim.push_back(64'd9);
        applyStimulus(2, 2, 0, "one_error");

        // Long m_axis stall on a single-copy job: only one word may get in.
        stim.delete();
        for (int i = 0; i < 5; i++) stim.push_back({$urandom, $urandom});
        ready_pct = 100; valid_pct = 100;
        @(negedge clk);
        snap_accepts = -1;
        stall_left   = 10;
        applyStimulus(1, 5, 0, "stall");
        checkOutput("stall single accept", snap_accepts, 1);

        // Empty job goes straight to status.
        stim.delete();
        applyStimulus(0, 7, 0, "count0");

        // Every repeated word wrong: 508 errors saturate.
        ready_pct = 80; valid_pct = 90;
        stim.delete();
        stim.push_back({$urandom, $urandom});
        stim.push_back({$urandom, $urandom});
        for (int i = 2; i < 510; i++) stim.push_back(stim[i % 2] ^ 64'h1);
        applyStimulus(255, 2, 0, "saturate");

        // Reset in the middle of the checking phase, then a tiny job.
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back({$urandom, $urandom});
        applyStimulus(3, 4, 6, "abort");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("midjob reset config_ready", config_ready, 0);
        checkOutput("midjob reset s_axis_tready", s_axis_tready, 0);
        checkOutput("midjob reset status_valid", status_valid, 0);
        checkOutput("midjob reset errcount", status_errcount, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stim.delete();
        stim.push_back(64'h0123_4567_89AB_CDEF);
        applyStimulus(1, 1, 0, "after_reset");

        // Random jobs with random gaps and occasional corrupted repeats.
        ready_pct = 60; valid_pct = 70; status_pct = 60;
        for (int j = 0; j < 10; j++) begin
            cnt   = $urandom_range(0, 5);
            sz    = $urandom_range(0, 8);
            total = cnt * sz;
            stim.delete();
            for (int i = 0; i < total; i++) begin
                if (i < sz) begin
                    w = {$urandom, $urandom};
                end else begin
                    w = stim[i % sz];
                    if ($urandom_range(3) == 0) w = w ^ (64'd1 << $urandom_range(63));
                end
                stim.push_back(w);
            end
            applyStimulus(cnt, sz, 0, $sformatf("rand%0d", j));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
